video_wb_arbiter: RTL and testbench

Two-master Wishbone arbiter sharing the single RAM master port between the video_in writer (master 0) and the video_out reader (master 1). Grants are registered with round-robin tie-break and held for a whole cycle/locked burst. The granted master's signals are muxed onto the shared port, and ACK/data are routed back to the owner only. Sits between the two video DMA engines and the system Wishbone interconnect.

---
 rtl/video_wb_pkg.sv | 25 ++
 rtl/video_wb_watchdog.sv | 68 ++++++
 rtl/video_wb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_video_wb_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_wb_pkg.sv
//------------------------------------------------------------------------------
// Module   : video_wb_pkg
// Purpose  : Shared types and constants for the video Wishbone arbiter.
//            arb_state_t is encoded so that the state value equals the
//            one-hot grant vector (IDLE = 00, OWN0 = 01, OWN1 = 10).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package video_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_t;

    // Index of a master: 0 = video_in writer, 1 = video_out reader
    typedef logic owner_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

`default_nettype wire

// File: rtl/video_wb_watchdog.sv
//------------------------------------------------------------------------------
// Module   : video_wb_watchdog
// Purpose  : Stall watchdog for the shared Wishbone port. Counts cycles with
//            STB high and no ACK; flags expiry on the TIMEOUT_CYCLES-th such
//            cycle and masks the timed-out master until its CYC is seen low.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            stall          - shared STB_O high and ACK_I low this cycle
//            ack            - shared ACK_I
//            leave          - current owner is giving up the port this cycle
//            owner          - index of the current owner
//            cyc[1:0]       - raw CYC_I of both masters
//            expire         - expiry pulse (combinational, one cycle)
//            mask[1:0]      - per-master arbitration mask
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module video_wb_watchdog
    import video_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       ack,
    input  logic       leave,
    input  owner_t     owner,
    input  logic [1:0] cyc,
    output logic       expire,
    output logic [1:0] mask
);

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count;

    // count holds the number of stalled cycles already seen, so the
    // TIMEOUT_CYCLES-th stalled cycle is the one where count == LAST_COUNT.
    assign expire = stall && (count == LAST_COUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            mask  <= 2'b00;
        end else begin
            if (ack || leave || expire)
                count <= '0;
            else if (stall)
                count <= count + 16'd1;

            // Setting wins over clearing so a master that times out while
            // still holding CYC stays masked until it visibly drops CYC.
            if (expire && (owner == 1'b0))
                mask[0] <= 1'b1;
            else if (!cyc[0])
                mask[0] <= 1'b0;

            if (expire && (owner == 1'b1))
                mask[1] <= 1'b1;
            else if (!cyc[1])
                mask[1] <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/video_wb_arbiter.sv
//------------------------------------------------------------------------------
// Module   : video_wb_arbiter
// Purpose  : Two-master Wishbone arbiter. Master 0 = video_in writer,
//            master 1 = video_out reader, sharing one RAM master port.
//            Registered grant, round-robin tie-break, grant held for a whole
//            CYC / LOCK burst, zero-dead-cycle handover to a waiting master.
// Ports    : clk, RST                   - clock, async active-high reset
//            p_wbN_*_I / p_wbN_*_O      - master N side (N = 0, 1)
//            p_wb_*_O / p_wb_*_I        - shared slave-facing port
//            grant[1:0]                 - one-hot owner, 00 when idle
//            timeout_irq                - watchdog expiry pulse
// Config   : VIDEO_WB_ARB_TIMEOUT_EN    - enables the stall watchdog
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module video_wb_arbiter
    import video_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        p_wb0_STB_I,
    input  logic        p_wb0_CYC_I,
    input  logic        p_wb0_LOCK_I,
    input  logic        p_wb0_WE_I,
    input  logic [3:0]  p_wb0_SEL_I,
    input  logic [31:0] p_wb0_ADR_I,
    input  logic [31:0] p_wb0_DAT_I,
    output logic        p_wb0_ACK_O,
    output logic        p_wb0_ERR_O,
    output logic [31:0] p_wb0_DAT_O,
    input  logic        p_wb1_STB_I,
    input  logic        p_wb1_CYC_I,
    input  logic        p_wb1_LOCK_I,
    input  logic        p_wb1_WE_I,
    input  logic [3:0]  p_wb1_SEL_I,
    input  logic [31:0] p_wb1_ADR_I,
    input  logic [31:0] p_wb1_DAT_I,
    output logic        p_wb1_ACK_O,
    output logic        p_wb1_ERR_O,
    output logic [31:0] p_wb1_DAT_O,
    output logic        p_wb_STB_O,
    output logic        p_wb_CYC_O,
    output logic        p_wb_LOCK_O,
    output logic        p_wb_WE_O,
    output logic [3:0]  p_wb_SEL_O,
    output logic [31:0] p_wb_ADR_O,
    output logic [31:0] p_wb_DAT_O,
    input  logic        p_wb_ACK_I,
    input  logic [31:0] p_wb_DAT_I,
    output logic [1:0]  grant,
    output logic        timeout_irq
);

    arb_state_t state;
    owner_t     last_owner;
    owner_t     owner;
    logic [1:0] cyc;
    logic [1:0] mask;
    logic [1:0] req;
    logic       own_cyc;
    logic       own_lock;
    logic       release_now;
    logic       expire;
    logic       leave;

    assign cyc         = {p_wb1_CYC_I, p_wb0_CYC_I};
    assign req         = cyc & ~mask;
    assign owner       = (state == OWN1);
    assign own_cyc     = owner ? p_wb1_CYC_I  : p_wb0_CYC_I;
    assign own_lock    = owner ? p_wb1_LOCK_I : p_wb0_LOCK_I;
    // LOCK keeps the grant across a CYC gap; only both low releases.
    assign release_now = (state != IDLE) && !own_cyc && !own_lock;
    assign leave       = release_now || expire;

`ifdef VIDEO_WB_ARB_TIMEOUT_EN
    video_wb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (RST),
        .stall  (p_wb_STB_O && !p_wb_ACK_I),
        .ack    (p_wb_ACK_I),
        .leave  (leave),
        .owner  (owner),
        .cyc    (cyc),
        .expire (expire),
        .mask   (mask)
    );
`else
    logic [15:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 16'(TIMEOUT_CYCLES);
    assign expire = 1'b0;
    assign mask   = 2'b00;
`endif

    // State encoding doubles as the registered one-hot grant.
    assign grant       = state;
    assign timeout_irq = expire;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            last_owner <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req == 2'b11)
                        state <= last_owner ? OWN0 : OWN1;
                    else if (req[0])
                        state <= OWN0;
                    else if (req[1])
                        state <= OWN1;
                end
                OWN0: begin
                    if (leave) begin
                        last_owner <= 1'b0;
                        state      <= req[1] ? OWN1 : IDLE;
                    end
                end
                OWN1: begin
                    if (leave) begin
                        last_owner <= 1'b1;
                        state      <= req[0] ? OWN0 : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        p_wb_STB_O  = 1'b0;
        p_wb_CYC_O  = 1'b0;
        p_wb_LOCK_O = 1'b0;
        p_wb_WE_O   = 1'b0;
        p_wb_SEL_O  = 4'h0;
        p_wb_ADR_O  = 32'h0;
        p_wb_DAT_O  = 32'h0;
        p_wb0_ACK_O = 1'b0;
        p_wb0_ERR_O = 1'b0;
        p_wb0_DAT_O = 32'h0;
        p_wb1_ACK_O = 1'b0;
        p_wb1_ERR_O = 1'b0;
        p_wb1_DAT_O = 32'h0;
        case (state)
            OWN0: begin
                p_wb_STB_O  = p_wb0_STB_I;
                p_wb_CYC_O  = p_wb0_CYC_I;
                p_wb_LOCK_O = p_wb0_LOCK_I;
                p_wb_WE_O   = p_wb0_WE_I;
                p_wb_SEL_O  = p_wb0_SEL_I;
                p_wb_ADR_O  = p_wb0_ADR_I;
                p_wb_DAT_O  = p_wb0_DAT_I;
                p_wb0_ACK_O = p_wb_ACK_I;
                p_wb0_ERR_O = expire;
                p_wb0_DAT_O = p_wb_DAT_I;
            end
            OWN1: begin
                p_wb_STB_O  = p_wb1_STB_I;
                p_wb_CYC_O  = p_wb1_CYC_I;
                p_wb_LOCK_O = p_wb1_LOCK_I;
                p_wb_WE_O   = p_wb1_WE_I;
                p_wb_SEL_O  = p_wb1_SEL_I;
                p_wb_ADR_O  = p_wb1_ADR_I;
                p_wb_DAT_O  = p_wb1_DAT_I;
                p_wb1_ACK_O = p_wb_ACK_I;
                p_wb1_ERR_O = expire;
                p_wb1_DAT_O = p_wb_DAT_I;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_video_wb_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_video_wb_arbiter
// Purpose  : Self-checking bench for video_wb_arbiter: directed sequences,
//            a vector table for tie-break / handover / locked burst, and a
//            randomized run against a behavioural model of the arbiter.
// Config   : VIDEO_WB_ARB_TIMEOUT_EN selects the watchdog sequence.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_video_wb_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        RST;
    logic        cyc_m  [2];
    logic        stb_m  [2];
    logic        lock_m [2];
    logic        we_m   [2];
    logic [3:0]  sel_m  [2];
    logic [31:0] adr_m  [2];
    logic [31:0] wdat_m [2];
    logic        ack_i;
    logic [31:0] rdat_i;

    logic        ack0, err0, ack1, err1;
    logic [31:0] dat0, dat1;
    logic        stb_o, cyc_o, lock_o, we_o;
    logic [3:0]  sel_o;
    logic [31:0] adr_o, dat_o;
    logic [1:0]  grant;
    logic        irq;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    video_wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .RST          (RST),
        .p_wb0_STB_I  (stb_m[0]),
        .p_wb0_CYC_I  (cyc_m[0]),
        .p_wb0_LOCK_I (lock_m[0]),
        .p_wb0_WE_I   (we_m[0]),
        .p_wb0_SEL_I  (sel_m[0]),
        .p_wb0_ADR_I  (adr_m[0]),
        .p_wb0_DAT_I  (wdat_m[0]),
        .p_wb0_ACK_O  (ack0),
        .p_wb0_ERR_O  (err0),
        .p_wb0_DAT_O  (dat0),
        .p_wb1_STB_I  (stb_m[1]),
        .p_wb1_CYC_I  (cyc_m[1]),
        .p_wb1_LOCK_I (lock_m[1]),
        .p_wb1_WE_I   (we_m[1]),
        .p_wb1_SEL_I  (sel_m[1]),
        .p_wb1_ADR_I  (adr_m[1]),
        .p_wb1_DAT_I  (wdat_m[1]),
        .p_wb1_ACK_O  (ack1),
        .p_wb1_ERR_O  (err1),
        .p_wb1_DAT_O  (dat1),
        .p_wb_STB_O   (stb_o),
        .p_wb_CYC_O   (cyc_o),
        .p_wb_LOCK_O  (lock_o),
        .p_wb_WE_O    (we_o),
        .p_wb_SEL_O   (sel_o),
        .p_wb_ADR_O   (adr_o),
        .p_wb_DAT_O   (dat_o),
        .p_wb_ACK_I   (ack_i),
        .p_wb_DAT_I   (rdat_i),
        .grant        (grant),
        .timeout_irq  (irq)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic zero_inputs();
        for (int n = 0; n < 2; n++) begin
            cyc_m[n] = 0; stb_m[n] = 0; lock_m[n] = 0; we_m[n] = 0;
            sel_m[n] = 4'h0; adr_m[n] = 32'h0; wdat_m[n] = 32'h0;
        end
        ack_i = 0; rdat_i = 32'h0;
    endtask

    task automatic req(input int n, input logic c, input logic l);
        cyc_m[n] = c; stb_m[n] = c; lock_m[n] = l;
    endtask

    task automatic do_reset();
        @(negedge clk);
        RST = 1'b1;
        zero_inputs();
        @(negedge clk);
        @(negedge clk);
        RST = 1'b0;
    endtask

    // Full observable output vector, 143 bits.
    function automatic logic [142:0] actual_vec();
        return {grant, stb_o, cyc_o, lock_o, we_o, sel_o, adr_o, dat_o,
                ack0, ack1, dat0, dat1, err0, err1, irq};
    endfunction

    // Behavioural model: owner (-1 = none) and the master served last.
    int m_owner;
    int m_last;

    function automatic logic [142:0] model_vec();
        logic [1:0] g;
        int o;
        if (m_owner < 0) return '0;
        o = m_owner;
        g = (o == 0) ? 2'b01 : 2'b10;
        return {g, stb_m[o], cyc_m[o], lock_m[o], we_m[o], sel_m[o], adr_m[o], wdat_m[o],
                (o == 0) ? ack_i : 1'b0, (o == 1) ? ack_i : 1'b0,
                (o == 0) ? rdat_i : 32'h0, (o == 1) ? rdat_i : 32'h0, 3'b000};
    endfunction

    task automatic model_step();
        int other;
        if (m_owner < 0) begin
            if (cyc_m[0] && cyc_m[1]) m_owner = 1 - m_last;
            else if (cyc_m[0])        m_owner = 0;
            else if (cyc_m[1])        m_owner = 1;
        end else if (!cyc_m[m_owner] && !lock_m[m_owner]) begin
            m_last  = m_owner;
            other   = 1 - m_owner;
            m_owner = cyc_m[other] ? other : -1;
        end
    endtask

    typedef struct {
        logic c0, l0, c1, l1, ack;
        logic [1:0] g;
        logic a0, a1, co;
    } vec_t;

    vec_t tbl [15];

    initial begin
        RST = 1'b1;
        zero_inputs();

        // ---- reset state ----
        @(negedge clk); #1;
        check("reset_state", actual_vec(), '0);
        do_reset();

        // ---- master 0 alone ----
        @(negedge clk);
        req(0, 1, 0); we_m[0] = 1; adr_m[0] = 32'h1000; wdat_m[0] = 32'h1234_5678; sel_m[0] = 4'hF;
        #1 check("m0_idle_cycle_grant", grant, 2'b00);
        @(negedge clk);
        ack_i = 1; rdat_i = 32'hCAFE_F00D;
        #1 check("m0_grant", grant, 2'b01);
        check("m0_shared_port", {adr_o, we_o, cyc_o, stb_o, dat_o}, {32'h1000, 1'b1, 1'b1, 1'b1, 32'h1234_5678});
        check("m0_ack_route", {ack0, ack1, dat0, dat1}, {1'b1, 1'b0, 32'hCAFE_F00D, 32'h0});
        @(negedge clk);
        zero_inputs();
        @(negedge clk);

        // ---- tie-break, handover, locked burst with CYC gap ----
        //          c0 l0 c1 l1 ack   g     a0 a1 co
        tbl[0]  = '{1, 0, 1, 0, 0, 2'b00, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 0, 1, 2'b10, 0, 1, 1};
        tbl[2]  = '{1, 0, 0, 0, 0, 2'b10, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 0, 1, 2'b01, 1, 0, 1};
        tbl[4]  = '{0, 0, 1, 0, 0, 2'b01, 0, 0, 0};
        tbl[5]  = '{1, 0, 1, 1, 1, 2'b10, 0, 1, 1};
        tbl[6]  = '{1, 0, 1, 1, 1, 2'b10, 0, 1, 1};
        tbl[7]  = '{1, 0, 0, 1, 0, 2'b10, 0, 0, 0};
        tbl[8]  = '{1, 0, 0, 1, 0, 2'b10, 0, 0, 0};
        tbl[9]  = '{1, 0, 1, 1, 1, 2'b10, 0, 1, 1};
        tbl[10] = '{1, 0, 1, 0, 1, 2'b10, 0, 1, 1};
        tbl[11] = '{1, 0, 0, 0, 0, 2'b10, 0, 0, 0};
        tbl[12] = '{1, 0, 0, 0, 0, 2'b01, 0, 0, 1};
        tbl[13] = '{0, 0, 0, 0, 0, 2'b01, 0, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            req(0, tbl[i].c0, tbl[i].l0);
            req(1, tbl[i].c1, tbl[i].l1);
            ack_i = tbl[i].ack;
            #1 check($sformatf("table_row%0d", i), {grant, ack0, ack1, cyc_o},
                     {tbl[i].g, tbl[i].a0, tbl[i].a1, tbl[i].co});
        end

        // ---- asynchronous reset mid-burst ----
        do_reset();
        @(negedge clk); req(0, 1, 1);
        @(negedge clk); ack_i = 1;
        @(negedge clk);
        @(negedge clk);
        #1 check("burst_beat3_owned", {grant, cyc_o}, {2'b01, 1'b1});
        #1 RST = 1'b1;
        #1 check("async_reset_drop", {grant, cyc_o, stb_o}, 4'b0000);
        @(negedge clk); ack_i = 0; req(0, 1, 0); req(1, 1, 0);
        @(negedge clk); RST = 1'b0;
        @(negedge clk);
        #1 check("post_reset_tie_m1", grant, 2'b10);
        zero_inputs();
        @(negedge clk);
        @(negedge clk);

`ifdef VIDEO_WB_ARB_TIMEOUT_EN
        // ---- watchdog expiry ----
        do_reset();
        @(negedge clk); req(0, 1, 0);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            if (k == 1) req(1, 1, 0);
            #1;
            if (k < TO)
                check($sformatf("stall_cycle%0d", k), {grant, err0, err1, irq}, {2'b01, 3'b000});
            else
                check("timeout_expiry", {grant, err0, err1, irq}, {2'b01, 3'b101});
        end
        @(negedge clk);
        #1 check("timeout_handover_m1", {grant, err0, irq}, {2'b10, 2'b00});
        req(1, 0, 0);
        @(negedge clk);
        #1 check("masked_m0_idle1", grant, 2'b00);
        @(negedge clk);
        req(0, 0, 0);
        #1 check("masked_m0_idle2", grant, 2'b00);
        @(negedge clk);
        req(0, 1, 0);
        #1 check("unmasked_idle", grant, 2'b00);
        @(negedge clk);
        #1 check("m0_regranted", grant, 2'b01);
        zero_inputs();
        @(negedge clk);
`else
        // ---- stalled slave holds grant indefinitely ----
        do_reset();
        @(negedge clk); req(0, 1, 0);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            #1 check($sformatf("stall_hold%0d", k), {grant, err0, err1, irq}, {2'b01, 3'b000});
        end
        zero_inputs();
        @(negedge clk);
`endif

        // ---- randomized run against the behavioural model ----
        do_reset();
        m_owner = -1;
        m_last  = 0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            for (int n = 0; n < 2; n++) begin
                cyc_m[n]  = ($urandom_range(0, 1) == 1);
                stb_m[n]  = ($urandom_range(0, 1) == 1);
                lock_m[n] = ($urandom_range(0, 3) == 0);
                we_m[n]   = ($urandom_range(0, 1) == 1);
                sel_m[n]  = 4'($urandom);
                adr_m[n]  = $urandom;
                wdat_m[n] = $urandom;
            end
            // An ACK at least every 4th cycle keeps any watchdog quiet.
            ack_i  = ($urandom_range(0, 1) == 1) || (t % 4 == 0);
            rdat_i = $urandom;
            #1 check($sformatf("random_cycle%0d", t), actual_vec(), model_vec());
            @(posedge clk);
            model_step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
